// File: rtl/led_disp_pkg.sv
// ============================================================================
// led_disp_pkg - shared constants, segment patterns and helpers for the
//                multiplexed LED display path.
// Revision: 1.0
// ============================================================================
`default_nettype none

package led_disp_pkg;

  localparam int LED_SEG_W  = 7;
  localparam int LED_DIGITS = 6;

  // Segment bit order is {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  // Ceiling log2, never less than 1 so it can size a counter directly.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width = width + 1;
    return width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_scan_timer.sv
// ============================================================================
// led_scan_timer - slot counter, digit counter, frame-boundary strobe and
//                  registered frame tick for the digit scan.
// Revision: 1.0
// ============================================================================
`default_nettype none

module led_scan_timer
  import led_disp_pkg::*;
#(
  parameter int DIGITS   = 6,
  parameter int SLOT_CYC = 8192,
  parameter int SLOT_W   = clog2(SLOT_CYC),
  parameter int DIG_W    = clog2(DIGITS)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [SLOT_W-1:0] slot_cnt_o,
  output logic [DIG_W-1:0]  digit_o,
  output logic              frame_end_o,
  output logic              frame_tick_o
);

  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SLOT_CYC - 1);
  localparam logic [DIG_W-1:0]  DIGIT_LAST = DIG_W'(DIGITS - 1);

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [DIG_W-1:0]  digit_q, digit_d;
  logic              tick_q;
  logic              frame_end;

  always_comb begin
    slot_d    = slot_q + SLOT_W'(1);
    digit_d   = digit_q;
    frame_end = (digit_q == DIGIT_LAST) && (slot_q == SLOT_LAST);
    if (slot_q == SLOT_LAST) begin
      digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + DIG_W'(1);
    end
  end

  // The tick lands on the first cycle of digit 0 that follows a boundary,
  // so the frame right after reset carries no tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q  <= '0;
      digit_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      digit_q <= digit_d;
      tick_q  <= frame_end;
    end
  end

  assign slot_cnt_o   = slot_q;
  assign digit_o      = digit_q;
  assign frame_end_o  = frame_end;
  assign frame_tick_o = tick_q;

endmodule

`default_nettype wire

// File: rtl/led_disp_mux.sv
// ============================================================================
// led_disp_mux - N-digit 7-segment scan driver with double-buffered frames,
//                PWM brightness and blanking. Define LED_DISP_MUX_DEADTIME_EN
//                to add per-slot anti-ghosting dead time.
// Revision: 1.0
// ============================================================================
`default_nettype none

module led_disp_mux
  import led_disp_pkg::*;
#(
  parameter int DIGITS   = 6,
  parameter int SEG_W    = 7,
  parameter int SLOT_CYC = 8192,
  parameter int BRIGHT_W = 4,
  parameter int DEAD_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DIGITS*SEG_W-1:0] i_digit_seg,
  input  logic [DIGITS-1:0]       i_digit_dp,
  input  logic [BRIGHT_W-1:0]     i_bright,
  input  logic                    i_blank,
  output logic [SEG_W-1:0]        o_seg,
  output logic                    o_seg_dp,
  output logic [DIGITS-1:0]       o_seg_enb,
  output logic                    o_frame_tick
);

  localparam int SLOT_W = clog2(SLOT_CYC);
  localparam int DIG_W  = clog2(DIGITS);

`ifdef LED_DISP_MUX_DEADTIME_EN
  localparam bit DEAD_EN = 1'b1;
`else
  localparam bit DEAD_EN = 1'b0;
`endif

  logic [SLOT_W-1:0] slot_cnt;
  logic [DIG_W-1:0]  digit;
  logic              frame_end;

  led_scan_timer #(
    .DIGITS   (DIGITS),
    .SLOT_CYC (SLOT_CYC),
    .SLOT_W   (SLOT_W),
    .DIG_W    (DIG_W)
  ) u_scan_timer (
    .clk          (clk),
    .rst          (rst),
    .slot_cnt_o   (slot_cnt),
    .digit_o      (digit),
    .frame_end_o  (frame_end),
    .frame_tick_o (o_frame_tick)
  );

  logic [DIGITS*SEG_W-1:0] shadow_seg_q;
  logic [DIGITS-1:0]       shadow_dp_q;
  logic [BRIGHT_W-1:0]     shadow_bright_q;
  logic                    load_pending_q;
  logic                    blank_q;
  logic [SEG_W-1:0]        seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [DIGITS-1:0]       enb_q, enb_d;
  logic                    load;
  logic                    lit;
  logic                    in_dead;
  logic [SEG_W-1:0]        sel_seg;
  logic                    sel_dp;

  assign load = frame_end | load_pending_q;

  always_comb begin
    sel_seg = '0;
    sel_dp  = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (digit == DIG_W'(k)) begin
        sel_seg = shadow_seg_q[k*SEG_W +: SEG_W];
        sel_dp  = shadow_dp_q[k];
      end
    end
    // PWM window: the slot's top BRIGHT_W bits sweep 0..2**BRIGHT_W-1.
    in_dead = DEAD_EN && (slot_cnt < SLOT_W'(DEAD_CYC));
    lit     = (slot_cnt[SLOT_W-1 -: BRIGHT_W] <= shadow_bright_q) && !blank_q && !in_dead;
    seg_d   = lit ? sel_seg : '0;
    dp_d    = lit ? sel_dp  : 1'b0;
    enb_d   = lit ? (DIGITS'(1) << digit) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_seg_q    <= '0;
      shadow_dp_q     <= '0;
      shadow_bright_q <= '0;
      load_pending_q  <= 1'b1;
      blank_q         <= 1'b0;
      seg_q           <= '0;
      dp_q            <= 1'b0;
      enb_q           <= '0;
    end else begin
      blank_q        <= i_blank;
      load_pending_q <= 1'b0;
      if (load) begin
        shadow_seg_q    <= i_digit_seg;
        shadow_dp_q     <= i_digit_dp;
        shadow_bright_q <= i_bright;
      end
      seg_q <= seg_d;
      dp_q  <= dp_d;
      enb_q <= enb_d;
    end
  end

  assign o_seg     = seg_q;
  assign o_seg_dp  = dp_q;
  assign o_seg_enb = enb_q;

endmodule

`default_nettype wire
